// File: rtl/alloc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alloc_req_arbiter
// Purpose  : Shares one allocator_tag_map request port among NUM_REQ ordering
//            units. Only one unit owns the allocator at a time. Ownership is
//            handed out round-robin, and every grant is counted per requester.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/req_id  - per-requester level request and original ID
//            req_gnt/req_uid   - per-requester grant, broadcast unique_id
//            alloc_req/alloc_in_id/alloc_gnt/unique_id - allocator port
//            busy/owner_idx    - lock status and current/last owner
//            grant_cnt         - saturating completed-grant counters
//            err_spurious_gnt  - sticky flag: allocator granted while unlocked
// Revision : 1.0 - initial release
// ============================================================================
module alloc_req_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ID_WIDTH  = 4,
    parameter int UID_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic [UID_WIDTH-1:0]          req_uid,
    output logic                          alloc_req,
    output logic [ID_WIDTH-1:0]           alloc_in_id,
    input  logic                          alloc_gnt,
    input  logic [UID_WIDTH-1:0]          unique_id,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner_idx,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt,
    output logic                          err_spurious_gnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_owner_idx;
    logic                    r_seen_gnt;
    logic                    r_err;
    logic [CNT_WIDTH-1:0]    r_grant_cnt [NUM_REQ];

    logic                    w_win_found;
    logic [IDX_W-1:0]        w_win_idx;
    int                      w_scan;
    logic                    w_owner_req;
    logic [ID_WIDTH-1:0]     w_owner_id;
    logic [NUM_REQ-1:0]      w_owner_onehot;
    logic [IDX_W-1:0]        w_rr_nxt;

    // Round-robin pick: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            if (!w_win_found && req_valid[IDX_W'(w_scan)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'(w_scan);
            end
        end
    end

    // Select the registered owner's request, ID and grant position.
    always_comb begin
        w_owner_req    = 1'b0;
        w_owner_id     = '0;
        w_owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == r_owner_idx) begin
                w_owner_req       = req_valid[i];
                w_owner_id        = req_id[i*ID_WIDTH +: ID_WIDTH];
                w_owner_onehot[i] = 1'b1;
            end
        end
    end

    assign w_rr_nxt = (r_owner_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                            : r_owner_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alloc_req   = 1'b0;
        alloc_in_id = '0;
        req_gnt     = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                alloc_req   = w_owner_req;
                alloc_in_id = w_owner_id;
                busy        = 1'b1;
                req_gnt     = w_owner_onehot & {NUM_REQ{alloc_gnt}};
                // Owner dropping its level request releases the allocator.
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_owner_idx <= '0;
            r_seen_gnt  <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else begin
            if (alloc_gnt && (r_state == S_IDLE)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_owner_idx <= w_win_idx;
                        r_seen_gnt  <= 1'b0;
                    end
                end
                S_LOCK: begin
                    if (alloc_gnt) begin
                        r_seen_gnt <= 1'b1;
                    end
                    if (!w_owner_req) begin
                        r_rr_ptr <= w_rr_nxt;
                        // A withdrawn request (no grant seen) is not counted.
                        if (r_seen_gnt && (r_grant_cnt[r_owner_idx] != '1)) begin
                            r_grant_cnt[r_owner_idx] <= r_grant_cnt[r_owner_idx]
                                                        + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            assign grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_grant_cnt[gi];
        end
    endgenerate

    assign req_uid          = unique_id;
    assign owner_idx        = r_owner_idx;
    assign err_spurious_gnt = r_err;

endmodule
`default_nettype wire
